// File: rtl/clint_bus_sched.sv
// Shares the CLINT register port between core loads/stores and a 64-bit mtimecmp
// programming port; each compare update is issued as LO<=ones, HI<=new, LO<=new.
module clint_bus_sched #(
    parameter int                XLEN     = 32,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] TCMP_OFS = 'h4000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_core_req,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic              i_core_we,
    input  logic [XLEN-1:0]   i_core_wdata,
    output logic              o_core_gnt,
    output logic [XLEN-1:0]   o_core_rdata,
    input  logic              i_tcmp_valid,
    input  logic [63:0]       i_tcmp_data,
    output logic              o_tcmp_ready,
    output logic              o_tcmp_done,
    output logic [ADDR_W-1:0] o_clint_addr,
    output logic              o_clint_we,
    output logic [XLEN-1:0]   o_clint_wdata,
    input  logic [XLEN-1:0]   i_clint_rdata
);

    localparam logic [ADDR_W-1:0] TCMP_HI_OFS = ADDR_W'(TCMP_OFS + ADDR_W'(4));

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEQ_HI = 2'd1,
        ST_SEQ_LO = 2'd2
    } state_t;

    typedef enum logic {
        PRIO_CORE = 1'b0,
        PRIO_TCMP = 1'b1
    } prio_t;

    state_t      state_q, state_nxt;
    prio_t       prio_q, prio_nxt;
    logic [63:0] tcmp_q;
    logic        tcmp_load;

    logic              core_gnt, tcmp_ready, tcmp_done, clint_we;
    logic [ADDR_W-1:0] clint_addr;
    logic [XLEN-1:0]   clint_wdata;
    logic              core_win, tcmp_win;

    // Alternating priority only matters when both sides ask in the same IDLE cycle.
    assign core_win = i_core_req && (!i_tcmp_valid || prio_q == PRIO_CORE);
    assign tcmp_win = i_tcmp_valid && !core_win;

    // NOTE: every combinational output gets a default before the case so no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        core_gnt    = 1'b0;
        tcmp_ready  = 1'b0;
        tcmp_done   = 1'b0;
        clint_addr  = i_core_addr;
        clint_we    = 1'b0;
        clint_wdata = '0;
        state_nxt   = state_q;
        prio_nxt    = prio_q;
        tcmp_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (core_win) begin
                    core_gnt    = 1'b1;
                    clint_we    = i_core_we;
                    clint_wdata = i_core_wdata;
                    prio_nxt    = PRIO_TCMP;
                end else if (tcmp_win) begin
                    tcmp_ready  = 1'b1;
                    clint_addr  = TCMP_OFS;
                    clint_we    = 1'b1;
                    clint_wdata = '1;
                    tcmp_load   = 1'b1;
                    prio_nxt    = PRIO_CORE;
                    state_nxt   = ST_SEQ_HI;
                end
            end
            ST_SEQ_HI: begin
                clint_addr  = TCMP_HI_OFS;
                clint_we    = 1'b1;
                clint_wdata = XLEN'(tcmp_q[63:32]);
                state_nxt   = ST_SEQ_LO;
            end
            ST_SEQ_LO: begin
                clint_addr  = TCMP_OFS;
                clint_we    = 1'b1;
                clint_wdata = XLEN'(tcmp_q[31:0]);
                tcmp_done   = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= PRIO_CORE;
            tcmp_q  <= '0;
        end else begin
            state_q <= state_nxt;
            prio_q  <= prio_nxt;
            if (tcmp_load) begin
                tcmp_q <= i_tcmp_data;
            end
        end
    end

    // Handshakes and the write strobe are forced low while reset is asserted, even
    // though the IDLE arbitration is combinational on the live requests.
    assign o_core_gnt    = core_gnt & i_rst_n;
    assign o_tcmp_ready  = tcmp_ready & i_rst_n;
    assign o_tcmp_done   = tcmp_done & i_rst_n;
    assign o_clint_we    = clint_we & i_rst_n;
    assign o_clint_addr  = clint_addr;
    assign o_clint_wdata = clint_wdata;
    assign o_core_rdata  = i_clint_rdata;

endmodule
